// File: rtl/mem_stage_if.sv
// ============================================================================
//  Module      : mem_stage_if
//  Description : Byte-serial memory-controller handshake between the MEM
//                pipeline stage (master) and the memory controller (slave).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    mcReq_out    master->slave  1           byte request
//    mcWe_out     master->slave  1           1 = write byte, 0 = read byte
//    mcAddr_out   master->slave  ADDR_WIDTH  byte address
//    mcWdata_out  master->slave  8           write byte
//    mcAck_in     slave->master  1           current byte completes this cycle
//    mcRdata_in   slave->master  8           read byte, valid with mcAck_in
// ============================================================================
`default_nettype none

interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mcReq_out;
    logic                  mcWe_out;
    logic [ADDR_WIDTH-1:0] mcAddr_out;
    logic [7:0]            mcWdata_out;
    logic                  mcAck_in;
    logic [7:0]            mcRdata_in;

    modport master (
        output mcReq_out,
        output mcWe_out,
        output mcAddr_out,
        output mcWdata_out,
        input  mcAck_in,
        input  mcRdata_in
    );

    modport slave (
        input  mcReq_out,
        input  mcWe_out,
        input  mcAddr_out,
        input  mcWdata_out,
        output mcAck_in,
        output mcRdata_in
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Loads/stores of 1, 2 or 4 bytes run one
//                byte at a time over the memory-controller handshake while
//                stall_out holds the upstream pipeline. Load results are sign-
//                or zero-extended. Non-memory ops pass through combinationally.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in       in   1           clock, rising edge
//    rst_in       in   1           asynchronous active-low reset
//    instIdx_in   in   INST_WIDTH  instruction index from EX_MEM
//    memAddr_in   in   ADDR_WIDTH  effective address
//    valStore_in  in   DATA_WIDTH  store data
//    rdE_in       in   1           rd write enable
//    rdIdx_in     in   5           rd index
//    rdData_in    in   DATA_WIDTH  ALU result for non-memory ops
//    rdE_out      out  1           to MEM_WB: rd write enable
//    rdIdx_out    out  5           to MEM_WB: rd index
//    rdData_out   out  DATA_WIDTH  to MEM_WB: rd data
//    stall_out    out  1           hold upstream, bubble MEM_WB
//    mc           master modport   memory-controller byte handshake
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    INST_WIDTH = 4,
    parameter logic [INST_WIDTH-1:0] ID_LB      = 4'd0,
    parameter logic [INST_WIDTH-1:0] ID_LH      = 4'd1,
    parameter logic [INST_WIDTH-1:0] ID_LW      = 4'd2,
    parameter logic [INST_WIDTH-1:0] ID_LBU     = 4'd3,
    parameter logic [INST_WIDTH-1:0] ID_LHU     = 4'd4,
    parameter logic [INST_WIDTH-1:0] ID_SB      = 4'd5,
    parameter logic [INST_WIDTH-1:0] ID_SH      = 4'd6,
    parameter logic [INST_WIDTH-1:0] ID_SW      = 4'd7
) (
    input  wire logic                  clk_in,
    input  wire logic                  rst_in,
    input  wire logic [INST_WIDTH-1:0] instIdx_in,
    input  wire logic [ADDR_WIDTH-1:0] memAddr_in,
    input  wire logic [DATA_WIDTH-1:0] valStore_in,
    input  wire logic                  rdE_in,
    input  wire logic [4:0]            rdIdx_in,
    input  wire logic [DATA_WIDTH-1:0] rdData_in,
    output logic                       rdE_out,
    output logic [4:0]                 rdIdx_out,
    output logic [DATA_WIDTH-1:0]      rdData_out,
    output logic                       stall_out,
    mem_stage_if.master                mc
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            k_q;      // byte index within the access
    logic [DATA_WIDTH-1:0] buf_q;    // assembled load bytes

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_signed;
    logic [1:0]            w_len_m1; // access length minus one
    logic                  w_is_mem;
    logic [DATA_WIDTH-1:0] w_ld_data;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_signed = 1'b0;
        w_len_m1    = 2'd0;
        case (instIdx_in)
            ID_LB:  begin w_is_load  = 1'b1; w_is_signed = 1'b1; w_len_m1 = 2'd0; end
            ID_LH:  begin w_is_load  = 1'b1; w_is_signed = 1'b1; w_len_m1 = 2'd1; end
            ID_LW:  begin w_is_load  = 1'b1;                     w_len_m1 = 2'd3; end
            ID_LBU: begin w_is_load  = 1'b1;                     w_len_m1 = 2'd0; end
            ID_LHU: begin w_is_load  = 1'b1;                     w_len_m1 = 2'd1; end
            ID_SB:  begin w_is_store = 1'b1;                     w_len_m1 = 2'd0; end
            ID_SH:  begin w_is_store = 1'b1;                     w_len_m1 = 2'd1; end
            ID_SW:  begin w_is_store = 1'b1;                     w_len_m1 = 2'd3; end
            default: ;
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;

    // Upper buffer bytes may hold stale data from an earlier, longer load,
    // so the extension is built from the access length, never the raw buffer.
    always_comb begin
        case (w_len_m1)
            2'd0:    w_ld_data = {{(DATA_WIDTH-8){w_is_signed & buf_q[7]}}, buf_q[7:0]};
            2'd1:    w_ld_data = {{(DATA_WIDTH-16){w_is_signed & buf_q[15]}}, buf_q[15:0]};
            default: w_ld_data = buf_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    k_q <= 2'd0;
                    if (w_is_mem) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mc.mcAck_in) begin
                        if (w_is_load) begin
                            buf_q[{k_q, 3'b000} +: 8] <= mc.mcRdata_in;
                        end
                        k_q <= k_q + 2'd1;
                        if (k_q == w_len_m1) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    k_q     <= 2'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    k_q     <= 2'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all forced low while reset is asserted, pass-through included
    // ------------------------------------------------------------------
    always_comb begin
        rdE_out        = 1'b0;
        rdIdx_out      = 5'd0;
        rdData_out     = '0;
        stall_out      = 1'b0;
        mc.mcReq_out   = 1'b0;
        mc.mcWe_out    = 1'b0;
        mc.mcAddr_out  = '0;
        mc.mcWdata_out = 8'd0;
        if (rst_in) begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_mem) begin
                        stall_out = 1'b1;
                    end else begin
                        rdE_out    = rdE_in;
                        rdIdx_out  = rdIdx_in;
                        rdData_out = rdData_in;
                    end
                end
                S_ACCESS: begin
                    stall_out      = 1'b1;
                    mc.mcReq_out   = 1'b1;
                    mc.mcWe_out    = w_is_store;
                    // Misaligned accesses wrap past the top of the address space.
                    mc.mcAddr_out  = memAddr_in + {{(ADDR_WIDTH-2){1'b0}}, k_q};
                    mc.mcWdata_out = valStore_in[{k_q, 3'b000} +: 8];
                end
                S_DONE: begin
                    rdIdx_out = rdIdx_in;
                    if (w_is_load) begin
                        rdE_out    = rdE_in;
                        rdData_out = w_ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage. Inputs change
//                1 time unit after the rising edge; outputs are checked
//                1 time unit after that.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam logic [3:0] C_LB  = 4'd0;
    localparam logic [3:0] C_LH  = 4'd1;
    localparam logic [3:0] C_LW  = 4'd2;
    localparam logic [3:0] C_LBU = 4'd3;
    localparam logic [3:0] C_SB  = 4'd5;
    localparam logic [3:0] C_SH  = 4'd6;
    localparam logic [3:0] C_NOP = 4'd8;
    localparam logic [3:0] C_ADD = 4'd9;

    logic        clk_in;
    logic        rst_in;
    logic [3:0]  instIdx_in;
    logic [31:0] memAddr_in;
    logic [31:0] valStore_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;
    logic        stall_out;

    int checks   = 0;
    int failures = 0;

    mem_stage_if #(.ADDR_WIDTH(32)) mc ();

    mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INST_WIDTH(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .instIdx_in  (instIdx_in),
        .memAddr_in  (memAddr_in),
        .valStore_in (valStore_in),
        .rdE_in      (rdE_in),
        .rdIdx_in    (rdIdx_in),
        .rdData_in   (rdData_in),
        .rdE_out     (rdE_out),
        .rdIdx_out   (rdIdx_out),
        .rdData_out  (rdData_out),
        .stall_out   (stall_out),
        .mc          (mc.master)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drives one memory access from the IDLE cycle through the DONE cycle.
    // Returns with the DUT in DONE; the caller advances upstream afterwards.
    task automatic do_mem(input string tag, input logic [3:0] inst, input logic [31:0] addr,
                          input logic [31:0] sval, input int n, input int waits,
                          input logic [31:0] rbytes, input logic we,
                          input logic exp_rde, input logic [31:0] exp_data);
        int stall_cnt;
        logic [31:0] exp_addr;
        logic [7:0]  exp_wb;
        stall_cnt   = 0;
        instIdx_in  = inst;
        memAddr_in  = addr;
        valStore_in = sval;
        rdE_in      = 1'b1;
        rdIdx_in    = 5'd7;
        rdData_in   = 32'hDEAD_BEEF;
        mc.mcAck_in = 1'b0;
        #1;
        check({tag, " idle stall"}, {31'd0, stall_out}, 32'd1);
        check({tag, " idle rdE"},   {31'd0, rdE_out},   32'd0);
        check({tag, " idle req"},   {31'd0, mc.mcReq_out}, 32'd0);
        if (stall_out) stall_cnt++;
        for (int k = 0; k < n; k++) begin
            exp_addr = addr + k;
            exp_wb   = sval[8*k +: 8];
            for (int w = 0; w <= waits; w++) begin
                tick();
                mc.mcAck_in  = (w == waits);
                mc.mcRdata_in = rbytes[8*k +: 8];
                #1;
                check($sformatf("%s byte%0d req", tag, k),   {31'd0, mc.mcReq_out}, 32'd1);
                check($sformatf("%s byte%0d addr", tag, k),  mc.mcAddr_out, exp_addr);
                check($sformatf("%s byte%0d we", tag, k),    {31'd0, mc.mcWe_out}, {31'd0, we});
                if (we) check($sformatf("%s byte%0d wdata", tag, k), {24'd0, mc.mcWdata_out}, {24'd0, exp_wb});
                check($sformatf("%s byte%0d rdE", tag, k),   {31'd0, rdE_out}, 32'd0);
                if (stall_out) stall_cnt++;
            end
        end
        tick();
        mc.mcAck_in = 1'b0;
        #1;
        check({tag, " done stall"}, {31'd0, stall_out}, 32'd0);
        check({tag, " done req"},   {31'd0, mc.mcReq_out}, 32'd0);
        check({tag, " done rdE"},   {31'd0, rdE_out}, {31'd0, exp_rde});
        check({tag, " done rdIdx"}, {27'd0, rdIdx_out}, 32'd7);
        check({tag, " done data"},  rdData_out, exp_data);
        check({tag, " stall cycles"}, stall_cnt, n * (waits + 1) + 1);
    endtask

    initial begin
        // Reset: outputs low even with a pass-through op presented
        rst_in      = 1'b0;
        instIdx_in  = C_ADD;
        memAddr_in  = 32'h0;
        valStore_in = 32'h0;
        rdE_in      = 1'b1;
        rdIdx_in    = 5'd5;
        rdData_in   = 32'h1234;
        mc.mcAck_in = 1'b0;
        mc.mcRdata_in = 8'h00;
        tick();
        tick();
        check("reset rdE",   {31'd0, rdE_out},   32'd0);
        check("reset data",  rdData_out,         32'd0);
        check("reset stall", {31'd0, stall_out}, 32'd0);
        check("reset req",   {31'd0, mc.mcReq_out}, 32'd0);
        rst_in = 1'b1;
        #1;

        // ADD pass-through, same cycle
        check("add rdE",   {31'd0, rdE_out},   32'd1);
        check("add rdIdx", {27'd0, rdIdx_out}, 32'd5);
        check("add data",  rdData_out,         32'h0000_1234);
        check("add stall", {31'd0, stall_out}, 32'd0);
        check("add req",   {31'd0, mc.mcReq_out}, 32'd0);

        // LW zero-wait
        tick();
        do_mem("lw", C_LW, 32'h100, 32'h0, 4, 0, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678);

        // LB / LBU of 0x80
        tick();
        do_mem("lb", C_LB, 32'h7, 32'h0, 1, 0, 32'h0000_0080, 1'b0, 1'b1, 32'hFFFF_FF80);
        tick();
        do_mem("lbu", C_LBU, 32'h7, 32'h0, 1, 0, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0080);

        // SH across the address wrap, two wait cycles per byte
        tick();
        do_mem("sh", C_SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 2, 32'h0, 1'b1, 1'b0, 32'h0);

        // LW abandoned by reset after the second ack
        tick();
        instIdx_in  = C_LW;
        memAddr_in  = 32'h200;
        mc.mcAck_in = 1'b0;
        tick();                              // now ACCESS k=0
        mc.mcAck_in = 1'b1; mc.mcRdata_in = 8'h11;
        tick();                              // k=1
        mc.mcRdata_in = 8'h22;
        tick();                              // k=2, two bytes acked
        mc.mcAck_in = 1'b0;
        #1;
        check("rst-mid addr before", mc.mcAddr_out, 32'h202);
        rst_in = 1'b0;
        #1;
        check("rst-mid stall", {31'd0, stall_out}, 32'd0);
        check("rst-mid req",   {31'd0, mc.mcReq_out}, 32'd0);
        check("rst-mid rdE",   {31'd0, rdE_out}, 32'd0);
        check("rst-mid data",  rdData_out, 32'd0);
        check("rst-mid addr",  mc.mcAddr_out, 32'd0);
        tick();
        rst_in = 1'b1;
        do_mem("lw-restart", C_LW, 32'h200, 32'h0, 4, 0, 32'hAABB_CCDD, 1'b0, 1'b1, 32'hAABB_CCDD);

        // LH then SB back-to-back
        tick();
        do_mem("lh", C_LH, 32'h41, 32'h0, 2, 1, 32'h0000_8001, 1'b0, 1'b1, 32'hFFFF_8001);
        tick();
        do_mem("sb", C_SB, 32'h50, 32'h0000_00A5, 1, 0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Upstream advances to a NOP; back to pass-through
        tick();
        instIdx_in = C_NOP;
        rdE_in     = 1'b0;
        rdData_in  = 32'h0;
        mc.mcAck_in = 1'b1;
        #1;
        check("nop stall", {31'd0, stall_out}, 32'd0);
        check("nop req",   {31'd0, mc.mcReq_out}, 32'd0);
        tick();
        check("nop ack ignored", {31'd0, stall_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
